// File: rtl/csr_hazard_ctrl.sv
// CSR-path pipeline controller: in-flight CSR write scoreboard (EX/MEM/WB), RAW stall,
// serializing-CSR drain/refetch, trap flush. Optional CSR_FWD_EN enables MEM/WB forwarding.
module csr_hazard_ctrl #(
  parameter logic [11:0] SER_ADDR0 = 12'h300,
  parameter logic [11:0] SER_ADDR1 = 12'h305,
  parameter logic [11:0] SER_ADDR2 = 12'h180,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             csr_rd_D,
  input  logic             csr_wr_D,
  input  logic [11:0]      csr_addr_D,
  input  logic             mem_stall,
  input  logic             trap_M,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       fwd_sel_D,
  output logic [CNT_W-1:0] stall_cnt
);

  // state   | meaning
  // IDLE    | normal issue, RAW checks active
  // DRAIN   | serializing write in flight, ID held until it retires from WB
  // REFETCH | one cycle: discard the stale instruction in ID
  typedef enum logic [1:0] {IDLE, DRAIN, REFETCH} state_t;

  state_t      state_q, state_d;
  logic        e_v, m_v, w_v;
  logic [11:0] e_addr, m_addr, w_addr, ser_addr_q;
  logic        raw_e, raw_m, raw_w, raw, is_ser;
  logic        id_hold, count, enter;
  logic [1:0]  fwd;

  always_comb begin
    raw_e  = csr_rd_D && e_v && (e_addr == csr_addr_D);
    raw_m  = csr_rd_D && m_v && (m_addr == csr_addr_D);
    raw_w  = csr_rd_D && w_v && (w_addr == csr_addr_D);
    is_ser = (csr_addr_D == SER_ADDR0) || (csr_addr_D == SER_ADDR1) ||
             (csr_addr_D == SER_ADDR2);
`ifdef CSR_FWD_EN
    raw = raw_e;
    fwd = raw_m ? 2'd1 : (raw_w ? 2'd2 : 2'd0);
`else
    raw = raw_e || raw_m || raw_w;
    fwd = 2'd0;
`endif
  end

  always_comb begin
    bubbleF = 1'b0; bubbleD = 1'b0; bubbleE = 1'b0; bubbleM = 1'b0; bubbleW = 1'b0;
    flushD  = 1'b0; flushE  = 1'b0; flushM  = 1'b0; flushW  = 1'b0;
    fwd_sel_D = 2'd0;
    state_d = state_q;
    id_hold = 1'b0;
    count   = 1'b0;
    enter   = 1'b0;
    if (rst_n) begin
      fwd_sel_D = fwd;
      if (trap_M) begin
        flushD = 1'b1; flushE = 1'b1; flushM = 1'b1;
        state_d = IDLE;
      end else if (mem_stall) begin
        bubbleF = 1'b1; bubbleD = 1'b1; bubbleE = 1'b1; bubbleM = 1'b1; bubbleW = 1'b1;
      end else begin
        case (state_q)
          DRAIN: begin
            // A coincident RAW match is already covered by this stall: one count.
            bubbleF = 1'b1; bubbleD = 1'b1; flushE = 1'b1;
            id_hold = 1'b1;
            count   = 1'b1;
            if (w_v && (w_addr == ser_addr_q)) state_d = REFETCH;
          end
          REFETCH: begin
            flushD  = 1'b1;
            id_hold = 1'b1;
            state_d = IDLE;
          end
          default: begin
            if (raw) begin
              bubbleF = 1'b1; bubbleD = 1'b1; flushE = 1'b1;
              id_hold = 1'b1;
              count   = 1'b1;
            end else if (csr_wr_D && is_ser) begin
              state_d = DRAIN;
              enter   = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      e_v        <= 1'b0; e_addr <= 12'h0;
      m_v        <= 1'b0; m_addr <= 12'h0;
      w_v        <= 1'b0; w_addr <= 12'h0;
      ser_addr_q <= 12'h0;
      stall_cnt  <= '0;
    end else if (trap_M) begin
      state_q <= IDLE;
      e_v     <= 1'b0;
      m_v     <= 1'b0;
      w_v     <= m_v;
      w_addr  <= m_addr;
    end else if (!mem_stall) begin
      state_q <= state_d;
      w_v     <= m_v;   w_addr <= m_addr;
      m_v     <= e_v;   m_addr <= e_addr;
      e_v     <= id_hold ? 1'b0 : csr_wr_D;
      e_addr  <= id_hold ? 12'h0 : csr_addr_D;
      if (enter) ser_addr_q <= csr_addr_D;
      if (count && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_csr_hazard_ctrl.sv
// Directed bench for csr_hazard_ctrl: expected outputs queued per driven cycle, popped
// and asserted once the combinational outputs settle. A CNT_W=4 copy checks saturation.
module tb_csr_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_rd_D = 1'b0, csr_wr_D = 1'b0, mem_stall = 1'b0, trap_M = 1'b0;
  logic [11:0] csr_addr_D = 12'h0;
  logic        bF, bD, bE, bM, bW, fD, fE, fM, fW;
  logic [1:0]  fwd;
  logic [15:0] cnt;
  logic        b4F, b4D, b4E, b4M, b4W, f4D, f4E, f4M, f4W;
  logic [1:0]  fwd4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  csr_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .csr_rd_D(csr_rd_D), .csr_wr_D(csr_wr_D),
    .csr_addr_D(csr_addr_D), .mem_stall(mem_stall), .trap_M(trap_M),
    .bubbleF(bF), .bubbleD(bD), .bubbleE(bE), .bubbleM(bM), .bubbleW(bW),
    .flushD(fD), .flushE(fE), .flushM(fM), .flushW(fW),
    .fwd_sel_D(fwd), .stall_cnt(cnt)
  );

  csr_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .csr_rd_D(csr_rd_D), .csr_wr_D(csr_wr_D),
    .csr_addr_D(csr_addr_D), .mem_stall(mem_stall), .trap_M(trap_M),
    .bubbleF(b4F), .bubbleD(b4D), .bubbleE(b4E), .bubbleM(b4M), .bubbleW(b4W),
    .flushD(f4D), .flushE(f4E), .flushM(f4M), .flushW(f4W),
    .fwd_sel_D(fwd4), .stall_cnt(cnt4)
  );

  // {bubbleF,D,E,M,W, flushD,E,M,W, fwd_sel_D}
  logic [10:0] obs_ctl;
  assign obs_ctl = {bF, bD, bE, bM, bW, fD, fE, fM, fW, fwd};

  localparam logic [10:0] NRM  = 11'b00000_0000_00;
  localparam logic [10:0] STL  = 11'b11000_0100_00;
  localparam logic [10:0] MST  = 11'b11111_0000_00;
  localparam logic [10:0] TRP  = 11'b00000_1110_00;
  localparam logic [10:0] REF  = 11'b00000_1000_00;
  localparam logic [10:0] FWDM = 11'b00000_0000_01;

  typedef struct packed {
    logic [10:0] ctl;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t  q[$];
  int    tests = 0, fails = 0, step = 0;
  string tname = "";

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s %s: got %b want %b", tname, tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [11:0] addr,
                     input logic ms, input logic tr, input logic [10:0] ctl, input int c);
    exp_t e;
    @(negedge clk);
    csr_rd_D = rd; csr_wr_D = wr; csr_addr_D = addr; mem_stall = ms; trap_M = tr;
    q.push_back('{ctl: ctl, cnt: 16'(c), cnt4: (c > 15) ? 4'd15 : 4'(c)});
    #1;
    e = q.pop_front();
    step++;
    tests++;
    assert (obs_ctl === e.ctl) else begin
      fails++;
      $error("FAIL %s ctl step %0d: got %b want %b", tname, step, obs_ctl, e.ctl);
    end
    tests++;
    assert (cnt === e.cnt) else begin
      fails++;
      $error("FAIL %s stall_cnt step %0d: got %0d want %0d", tname, step, cnt, e.cnt);
    end
    tests++;
    assert (cnt4 === e.cnt4) else begin
      fails++;
      $error("FAIL %s stall_cnt4 step %0d: got %0d want %0d", tname, step, cnt4, e.cnt4);
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    csr_rd_D = 1'b0; csr_wr_D = 1'b0; csr_addr_D = 12'h0; mem_stall = 1'b0; trap_M = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    tname = "T1_reset";
    for (int i = 0; i < 4; i++)
      cyc(1'($urandom), 1'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), NRM, 0);
    @(negedge clk);
    csr_rd_D = 1'b0; csr_wr_D = 1'b0; mem_stall = 1'b0; trap_M = 1'b0;
    rst_n = 1'b1;
    #1;
    chk_bit("sb_e_v", dut.e_v, 1'b0);
    chk_bit("sb_m_v", dut.m_v, 1'b0);
    chk_bit("sb_w_v", dut.w_v, 1'b0);

    tname = "T2_raw";
    rst_pulse();
    cyc(1'b0, 1'b1, 12'h341, 1'b0, 1'b0, NRM, 0);
    cyc(1'b1, 1'b0, 12'h341, 1'b0, 1'b0, STL, 0);
`ifdef CSR_FWD_EN
    cyc(1'b1, 1'b0, 12'h341, 1'b0, 1'b0, FWDM, 1);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 1);
`else
    cyc(1'b1, 1'b0, 12'h341, 1'b0, 1'b0, STL, 1);
    cyc(1'b1, 1'b0, 12'h341, 1'b0, 1'b0, STL, 2);
    cyc(1'b1, 1'b0, 12'h341, 1'b0, 1'b0, NRM, 3);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 3);
`endif

    tname = "T3_serialize";
    rst_pulse();
    cyc(1'b0, 1'b1, 12'h305, 1'b0, 1'b0, NRM, 0);
    // reads of 0x305 during drain overlap a RAW hit; each cycle must count once
    cyc(1'b1, 1'b0, 12'h305, 1'b0, 1'b0, STL, 0);
    cyc(1'b1, 1'b0, 12'h305, 1'b0, 1'b0, STL, 1);
    cyc(1'b1, 1'b0, 12'h305, 1'b0, 1'b0, STL, 2);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, REF, 3);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 3);
    cyc(1'b0, 1'b1, 12'h340, 1'b0, 1'b0, NRM, 3);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 3);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 3);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 3);

    tname = "T4_trap";
    rst_pulse();
    cyc(1'b0, 1'b1, 12'h300, 1'b0, 1'b0, NRM, 0);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, STL, 0);
    cyc(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, TRP, 1);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 1);
    chk_bit("sb_e_v", dut.e_v, 1'b0);
    chk_bit("sb_m_v", dut.m_v, 1'b0);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 1);

    tname = "T4_reset_mid_drain";
    rst_pulse();
    cyc(1'b0, 1'b1, 12'h180, 1'b0, 1'b0, NRM, 0);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, STL, 0);
    rst_pulse();
    #1;
    chk_bit("sb_e_v", dut.e_v, 1'b0);
    chk_bit("sb_m_v", dut.m_v, 1'b0);
    chk_bit("sb_w_v", dut.w_v, 1'b0);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 0);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 0);

    tname = "T5_mem_stall";
    rst_pulse();
    cyc(1'b0, 1'b1, 12'h341, 1'b0, 1'b0, NRM, 0);
    cyc(1'b1, 1'b0, 12'h341, 1'b0, 1'b0, STL, 0);
`ifdef CSR_FWD_EN
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 12'h341, 1'b1, 1'b0, MST | FWDM, 1);
    cyc(1'b1, 1'b0, 12'h341, 1'b0, 1'b0, FWDM, 1);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, 1);
`else
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 12'h341, 1'b1, 1'b0, MST, 1);
    cyc(1'b1, 1'b0, 12'h341, 1'b0, 1'b0, STL, 1);
    cyc(1'b1, 1'b0, 12'h341, 1'b0, 1'b0, STL, 2);
    cyc(1'b1, 1'b0, 12'h341, 1'b0, 1'b0, NRM, 3);
`endif

    tname = "T6_saturate";
    rst_pulse();
    c = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 12'h300, 1'b0, 1'b0, NRM, c);
      cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, STL, c);
      cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, STL, c + 1);
      cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, STL, c + 2);
      cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, REF, c + 3);
      c += 3;
    end
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, c);
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, NRM, c);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
